func_call_arbiter: RTL and testbench

//  Shares one function unit among NREQ requesters using the request/out/result call handshake.

---
 rtl/func_call_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_func_call_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/func_call_arbiter.sv
// -----------------------------------------------------------------------------
// func_call_arbiter
//
// Shares a single function unit among NREQ requesters. A requester raises req
// and holds its operand pair; the arbiter picks one requester round-robin,
// registers its operands, strobes fu_request for one cycle, waits for fu_out,
// and returns fu_result to that requester alone with a one-cycle done pulse.
//
// Optional feature macro: FUNC_ARB_TIMEOUT_EN
//   defined   : a call that sees no fu_out within TMO_CYC WAIT cycles completes
//               with result=0 and a timeout pulse alongside done.
//   undefined : WAIT is unbounded and timeout is tied low. The ports are the
//               same in both builds.
//
// Parameters
//   NREQ     number of requesters (2..8)
//   W        operand / result width
//   TMO_CYC  timeout limit in WAIT cycles (>= 2, fits in 16 bits)
//
// Ports
//   clock       in   single clock, all state on posedge
//   reset       in   asynchronous, active-high
//   req         in   per-requester level request, held until its done
//   in1_bus     in   operand 1, requester i at [i*W +: W]
//   in2_bus     in   operand 2, same packing
//   done        out  one-cycle, one-hot completion pulse to the granted requester
//   result      out  call result, held until the next done
//   busy        out  call in progress (ISSUE, WAIT or DONE)
//   timeout     out  one-cycle pulse with done on a timed-out call
//   fu_request  out  one-cycle call strobe to the function unit
//   fu_in1      out  registered operand 1, stable from ISSUE to DONE
//   fu_in2      out  registered operand 2
//   fu_out      in   function unit completion pulse
//   fu_result   in   function unit result, valid with fu_out
// -----------------------------------------------------------------------------
module func_call_arbiter #(
  parameter int NREQ    = 2,
  parameter int W       = 32,
  parameter int TMO_CYC = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] in1_bus,
  input  logic [NREQ*W-1:0] in2_bus,
  output logic [NREQ-1:0]   done,
  output logic [W-1:0]      result,
  output logic              busy,
  output logic              timeout,
  output logic              fu_request,
  output logic [W-1:0]      fu_in1,
  output logic [W-1:0]      fu_in2,
  input  logic              fu_out,
  input  logic [W-1:0]      fu_result
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Elaboration-time guard on the parameter ranges this design supports.
  if (NREQ < 2 || NREQ > 8 || TMO_CYC < 2 || TMO_CYC > 65535) begin : g_param_check
    $error("func_call_arbiter: parameter out of supported range");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   ptr_q, ptr_d;       // highest-priority requester for next pick
  logic [GW-1:0]   grant_q, grant_d;   // requester owning the current call
  logic [W-1:0]    opa_q, opa_d;
  logic [W-1:0]    opb_q, opb_d;
  logic [W-1:0]    result_q, result_d;

`ifdef FUNC_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);
  logic [15:0]     timer_q, timer_d;
  logic            tmo_q, tmo_d;
`endif

  // ---------------------------------------------------------------------------
  // Round-robin pick: first set req bit at or above ptr_q, wrapping at NREQ.
  // ---------------------------------------------------------------------------
  logic [GW-1:0] pick;
  logic [GW-1:0] cand;
  logic          found;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    pick  = ptr_q;
    cand  = ptr_q;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = GW'((int'(ptr_q) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
`ifdef FUNC_ARB_TIMEOUT_EN
      timer_q  <= '0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
`ifdef FUNC_ARB_TIMEOUT_EN
      timer_q  <= timer_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath-next logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
`ifdef FUNC_ARB_TIMEOUT_EN
    timer_d  = timer_q;
    tmo_d    = tmo_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_d = pick;
          // Constant-index mux keeps the operand capture width-exact.
          for (int i = 0; i < NREQ; i++) begin
            if (pick == GW'(i)) begin
              opa_d = in1_bus[i*W +: W];
              opb_d = in2_bus[i*W +: W];
            end
          end
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef FUNC_ARB_TIMEOUT_EN
        timer_d = '0;
        tmo_d   = 1'b0;
`endif
      end

      S_WAIT: begin
        // fu_out takes priority over the timeout limit in the same cycle.
        if (fu_out) begin
          result_d = fu_result;
          state_d  = S_DONE;
        end
`ifdef FUNC_ARB_TIMEOUT_EN
        else if (timer_q == TMO_LAST) begin
          result_d = '0;
          tmo_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
`endif
      end

      S_DONE: begin
        ptr_d   = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    done       = '0;
    busy       = (state_q != S_IDLE);
    fu_request = (state_q == S_ISSUE);
    timeout    = 1'b0;
    if (state_q == S_DONE) begin
      done[grant_q] = 1'b1;
`ifdef FUNC_ARB_TIMEOUT_EN
      timeout = tmo_q;
`endif
    end
  end

  assign result = result_q;
  assign fu_in1 = opa_q;
  assign fu_in2 = opb_q;

endmodule

// File: tb/tb_func_call_arbiter.sv
// -----------------------------------------------------------------------------
// tb_func_call_arbiter
//
// Drives func_call_arbiter with directed scenarios and a randomized phase,
// emulating the function unit (sum of operands after a chosen latency, plus
// optional stray fu_out pulses). A transaction-level model tracks the current
// call by edge timestamps and predicts every output; a negedge process
// compares the DUT to it each cycle. Directed scenarios add literal checks.
// -----------------------------------------------------------------------------
module tb_func_call_arbiter;

  localparam int NREQ = 3;
  localparam int W    = 32;
  localparam int TMO  = 4;

  logic              clock;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] in1_bus;
  logic [NREQ*W-1:0] in2_bus;
  logic [NREQ-1:0]   done;
  logic [W-1:0]      result;
  logic              busy;
  logic              timeout;
  logic              fu_request;
  logic [W-1:0]      fu_in1;
  logic [W-1:0]      fu_in2;
  logic              fu_out;
  logic [W-1:0]      fu_result;

  int n_tests = 0;
  int n_fail  = 0;

  func_call_arbiter #(.NREQ(NREQ), .W(W), .TMO_CYC(TMO)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .in1_bus    (in1_bus),
    .in2_bus    (in2_bus),
    .done       (done),
    .result     (result),
    .busy       (busy),
    .timeout    (timeout),
    .fu_request (fu_request),
    .fu_in1     (fu_in1),
    .fu_in2     (fu_in2),
    .fu_out     (fu_out),
    .fu_result  (fu_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one call record with edge timestamps.
  // ---------------------------------------------------------------------------
  int          edge_n;
  bit          m_active;
  int          m_win, m_issue, m_resp;
  bit          m_tmo;
  int          rr;
  bit          check_en;

  logic [NREQ-1:0] exp_done;
  logic [W-1:0]    exp_result, exp_fu_in1, exp_fu_in2;
  logic            exp_busy, exp_timeout, exp_fu_request;

  task automatic model_clear();
    m_active = 1'b0; m_win = 0; m_issue = 0; m_resp = -1; m_tmo = 1'b0; rr = 0;
    exp_done = '0; exp_result = '0; exp_fu_in1 = '0; exp_fu_in2 = '0;
    exp_busy = 1'b0; exp_timeout = 1'b0; exp_fu_request = 1'b0;
  endtask

  // Called just after each rising edge; req/fu_out still hold the values the
  // edge sampled.
  task automatic model_edge();
    int w;
    int idx;
    if (reset) begin
      model_clear();
      return;
    end
    if (!m_active) begin
      if (req != '0) begin
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
          idx = (rr + k) % NREQ;
          if (w < 0 && req[idx]) w = idx;
        end
        m_active = 1'b1; m_win = w; m_issue = edge_n; m_resp = -1; m_tmo = 1'b0;
        exp_fu_in1 = in1_bus[w*W +: W];
        exp_fu_in2 = in2_bus[w*W +: W];
      end
    end else if (m_resp < 0) begin
      // The unit's answer counts only from the second edge after the issue edge.
      if (edge_n >= m_issue + 2) begin
        if (fu_out) begin
          m_resp = edge_n; exp_result = fu_result;
        end
`ifdef FUNC_ARB_TIMEOUT_EN
        else if (edge_n - m_issue - 1 == TMO) begin
          m_resp = edge_n; exp_result = '0; m_tmo = 1'b1;
        end
`endif
      end
    end else begin
      m_active = 1'b0;
      rr = (m_win + 1) % NREQ;
    end
    exp_busy       = m_active;
    exp_fu_request = m_active && (edge_n == m_issue);
    exp_done       = '0;
    if (m_active && m_resp == edge_n) exp_done[m_win] = 1'b1;
    exp_timeout    = m_active && (m_resp == edge_n) && m_tmo;
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      check("done",       64'(done),       64'(exp_done));
      check("result",     64'(result),     64'(exp_result));
      check("busy",       64'(busy),       64'(exp_busy));
      check("timeout",    64'(timeout),    64'(exp_timeout));
      check("fu_request", 64'(fu_request), 64'(exp_fu_request));
      check("fu_in1",     64'(fu_in1),     64'(exp_fu_in1));
      check("fu_in2",     64'(fu_in2),     64'(exp_fu_in2));
    end
  end

  // ---------------------------------------------------------------------------
  // Function unit emulation
  // ---------------------------------------------------------------------------
  int         u_cnt, lat_min, lat_max;
  logic [W-1:0] u_a, u_b;
  bit         spur_en;

  task automatic unit_update();
    fu_out = 1'b0;
    if (u_cnt > 0) begin
      u_cnt--;
      if (u_cnt == 0) begin
        fu_out = 1'b1;
        fu_result = u_a + u_b;
      end
    end else if (spur_en && !fu_request && $urandom_range(0, 7) == 0) begin
      fu_out = 1'b1;
      fu_result = $urandom;
    end
    if (fu_request) begin
      u_cnt = int'($urandom_range(lat_max, lat_min));
      u_a = fu_in1;
      u_b = fu_in2;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    edge_n++;
    model_edge();
    unit_update();
  endtask

  task automatic reset_clean();
    reset = 1'b1;
    model_clear();
    u_cnt = 0;
    fu_out = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    in1_bus[i*W +: W] = a;
    in2_bus[i*W +: W] = b;
  endtask

  task automatic set_lat(input int l);
    lat_min = l;
    lat_max = l;
  endtask

  task automatic wait_done(input int budget, output logic [NREQ-1:0] d);
    d = '0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done != '0) begin
        d = done;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL wait_done: no done within %0d cycles (t=%0t)", budget, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0] d;
  logic [NREQ-1:0] rr_seq [4];

  initial begin
    reset = 1'b0; req = '0; in1_bus = '0; in2_bus = '0;
    fu_out = 1'b0; fu_result = '0;
    lat_min = 1; lat_max = 1; u_cnt = 0; spur_en = 1'b0;
    edge_n = 0; check_en = 1'b0;
    model_clear();
    #1 reset = 1'b1;
    model_clear();
    check_en = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_done",       64'(done),       64'd0);
    check("rst_busy",       64'(busy),       64'd0);
    check("rst_result",     64'(result),     64'd0);
    check("rst_fu_request", 64'(fu_request), 64'd0);
    check("rst_fu_in1",     64'(fu_in1),     64'd0);
    check("rst_timeout",    64'(timeout),    64'd0);

    // Single call, unit latency 3: done on the fifth edge after req is seen.
    set_lat(3);
    set_ops(0, 32'd5, 32'd7);
    req = 3'b001;
    tick();
    check("t1_fu_request", 64'(fu_request), 64'd1);
    check("t1_fu_in1",     64'(fu_in1),     64'd5);
    check("t1_fu_in2",     64'(fu_in2),     64'd7);
    tick();
    check("t1_strobe_once", 64'(fu_request), 64'd0);
    repeat (2) tick();
    check("t1_not_yet", 64'(done), 64'd0);
    tick();
    check("t1_done",   64'(done),   64'd1);
    check("t1_result", 64'(result), 64'd12);
    check("t1_busy",   64'(busy),   64'd1);
    req = '0;
    tick();
    check("t1_done_pulse", 64'(done), 64'd0);
    tick();
    check("t1_idle", 64'(busy), 64'd0);

    // Contention between requesters 0 and 1, held high.
    reset_clean();
    set_lat(1);
    set_ops(0, 32'd100, 32'd200);
    set_ops(1, 32'd101, 32'd201);
    rr_seq = '{3'b001, 3'b010, 3'b001, 3'b010};
    req = 3'b011;
    for (int j = 0; j < 4; j++) begin
      wait_done(20, d);
      check("t2_rr_grant", 64'(d), 64'(rr_seq[j]));
    end
    req = '0;
    repeat (3) tick();

    // Request arriving mid-call waits for the current call to finish.
    reset_clean();
    set_lat(4);
    req = 3'b001;
    tick();
    tick();
    req = 3'b011;
    wait_done(20, d);
    check("t3_first", 64'(d), 64'b001);
    req = 3'b010;
    tick();
    check("t3_no_overlap", 64'(fu_request), 64'd0);
    tick();
    check("t3_grant1_issue", 64'(fu_request), 64'd1);
    wait_done(20, d);
    check("t3_second", 64'(d), 64'b010);
    req = '0;
    repeat (3) tick();

    // Reset in WAIT; the unit's late answer must be ignored.
    reset_clean();
    set_lat(5);
    req = 3'b001;
    tick();
    tick();
    req = '0;
    reset = 1'b1;
    model_clear();
    tick();
    reset = 1'b0;
    repeat (6) tick();
    check("t4_done",   64'(done),   64'd0);
    check("t4_busy",   64'(busy),   64'd0);
    check("t4_result", 64'(result), 64'd0);
    set_lat(1);
    req = 3'b011;
    wait_done(20, d);
    check("t4_ptr_zero", 64'(d), 64'b001);
    req = '0;
    repeat (3) tick();

    // req dropped mid-call: call still completes, no regrant.
    reset_clean();
    set_lat(3);
    set_ops(0, 32'd20, 32'd22);
    req = 3'b001;
    tick();
    tick();
    req = '0;
    wait_done(20, d);
    check("t5_done",   64'(d),      64'b001);
    check("t5_result", 64'(result), 64'd42);
    repeat (4) tick();
    check("t5_no_regrant", 64'(busy), 64'd0);

    // Silent unit.
    set_lat(0);
    req = 3'b001;
    tick();
`ifdef FUNC_ARB_TIMEOUT_EN
    repeat (4) tick();
    check("t6_not_yet", 64'(done), 64'd0);
    tick();
    check("t6_done",    64'(done),    64'b001);
    check("t6_timeout", 64'(timeout), 64'd1);
    check("t6_result",  64'(result),  64'd0);
    req = '0;
    repeat (3) tick();
`else
    repeat (300) tick();
    check("t6_busy_hang", 64'(busy), 64'd1);
    check("t6_no_done",   64'(done), 64'd0);
    req = '0;
`endif
    reset_clean();

    // Randomized traffic with stray fu_out pulses.
    lat_min = 1;
    lat_max = 6;
    spur_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        in1_bus[i*W +: W] = $urandom;
        in2_bus[i*W +: W] = $urandom;
        if (done[i] && $urandom_range(0, 1) == 0) req[i] = 1'b0;
        else if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
      end
      tick();
    end
    req = '0;
    spur_en = 1'b0;
    set_lat(1);
    repeat (20) tick();
    check("drain_idle", 64'(busy), 64'd0);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
